convolution_coprocessor_index_sequencer: RTL and testbench
==========================================================

Name: convolution_coprocessor_index_sequencer

Overview:
- Control sequencer for the convolution coprocessor. Computes z[n] = sum over k of x[k]*y[n-k] for n = 0..size_x+size_y-2.
- Walks n and k and derives the y-index j = n-k with one internal convolution_coprocessor_substractor instance.
- Issues (x[k], y[j]) read-address pairs plus accumulate strobes to the MAC datapath, then one write strobe per output sample.
- Sits between the coprocessor register interface (start, sizes) and the memory/MAC datapath.

Parameters:
- ADDR_WIDTH, 5, address bits of the x and y sample memories (max 2^ADDR_WIDTH samples each).
- MAC_LATENCY, 2, cycles from the last accepted mac_en to the accumulator holding its final value (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle launch request; ignored while busy=1.
- size_x  input  ADDR_WIDTH+1  number of x samples; sampled on accepted start.
- size_y  input  ADDR_WIDTH+1  number of y samples; sampled on accepted start.
- mac_ready  input  1  datapath accepts the current mac_en beat.
- addr_x  output  ADDR_WIDTH  x read address (k).
- addr_y  output  ADDR_WIDTH  y read address (j = n-k).
- mac_en  output  1  multiply-accumulate request for addr_x/addr_y.
- acc_clr  output  1  clear accumulator, one-cycle pulse.
- addr_z  output  ADDR_WIDTH+1  output sample index n.
- z_wr  output  1  write accumulator to z[addr_z], one-cycle pulse.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  set when start arrives with size_x=0 or size_y=0; cleared on the next accepted start.

Behaviour:
- Reset (synchronous, active-high, effective at any time including mid-run): state goes to IDLE. All outputs 0, counters n, k and the wait counter are 0. Any in-flight mac_en is dropped. The datapath must be cleared by the next acc_clr.
- All outputs are registered.
- Subtractor is instantiated with DATA_WIDTH=ADDR_WIDTH+2: re_A = zero-extended n, re_B = zero-extended k.
  - j is in range when the sign bit of re_out is 0 and re_out < size_y.
  - addr_y = re_out[ADDR_WIDTH-1:0].
- IDLE: busy=0.
  - start with both sizes nonzero: latch sizes, n=0, go to CLEAR.
  - start with a zero size: err=1, go to DONE, issue no z_wr.
- CLEAR: acc_clr=1 for one cycle, k=k_first, go to SCAN.
- SCAN, one k evaluated per cycle when not stalled:
  - j in range: assert mac_en with addr_x=k, addr_y=j.
  - j out of range: keep mac_en=0; this costs one skip cycle.
  - Handshake: a beat transfers on an edge with mac_en=1 and mac_ready=1.
  - Stall: while mac_en=1 and mac_ready=0, addr_x, addr_y, mac_en and k hold.
  - After k=k_last is issued and accepted (or skipped), go to DRAIN.
- DRAIN: wait MAC_LATENCY cycles with mac_en=0. Then z_wr=1 for one cycle with addr_z=n.
  - If n = size_x+size_y-2: go to DONE.
  - Otherwise: n=n+1, go to CLEAR.
- DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- A start asserted in the DONE cycle is ignored; start must be re-asserted in IDLE.
- Default k range: k_first=0, k_last=size_x-1, so SCAN lasts size_x cycles plus stalls.
- Per-n cycle count with mac_ready tied high: 1 (CLEAR) + scan cycles + MAC_LATENCY + 1 (z_wr).
- size_x=size_y=2^ADDR_WIDTH: n reaches 2^(ADDR_WIDTH+1)-2 without overflow, and addr_z does not wrap.
- size_x=size_y=1: one mac_en, one z_wr at addr_z=0, then done.

Optional Feature:
- Macro: CONV_SEQ_BOUNDED_K_EN.
- Defined: k_first = max(0, n-size_y+1) and k_last = min(n, size_x-1), computed in CLEAR.
  - Every SCAN cycle issues mac_en and there are no skip cycles.
  - The in-range check remains as an assertion-only guard.
- Undefined: full 0..size_x-1 scan with skip cycles.
- Results, order and count of mac_en/z_wr beats are identical either way; only cycle count differs.

Test Plan:
- size_x=3, size_y=2, mac_ready=1, macro off:
  - mac_en pairs (addr_x,addr_y), in order: (0,0) | (0,1),(1,0) | (1,1),(2,0) | (2,1); 6 beats total.
  - z_wr at addr_z 0,1,2,3; acc_clr before each.
  - Per-n cycle count: 1 + 3 + MAC_LATENCY + 1 = 7 with MAC_LATENCY=2.
  - done after the last z_wr.
- Same stimulus, macro on: identical beat sequence; each n takes 1 + (number of beats for that n) + 3 cycles.
- mac_ready low for 3 cycles on the beat (1,0): addr_x=1, addr_y=0 and mac_en held stable for 3 cycles, with no duplicate beat and no skipped beat.
- start with size_y=0 → err=1, done pulse 2 cycles later, no mac_en or z_wr. A following valid start clears err.
- rst asserted in SCAN for n=1 → next cycle: all outputs 0, busy=0. A new start with size_x=size_y=1 → exactly one mac_en (0,0), one z_wr at 0, then done.
- start pulsed while busy=1 → ignored: sizes and sequence unchanged, single done at the end.

Source files
------------

// File: rtl/convolution_coprocessor_index_sequencer.sv
// Index sequencer for the convolution coprocessor: walks n and k, issues (x[k], y[n-k]) MAC beats and z writes.
// Optional macro CONV_SEQ_BOUNDED_K_EN restricts k to the in-range window so no skip cycles occur.

module convolution_coprocessor_substractor #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] re_A,
    input  logic [DATA_WIDTH-1:0] re_B,
    output logic [DATA_WIDTH-1:0] re_out
);
    assign re_out = re_A - re_B;
endmodule

module convolution_coprocessor_index_sequencer #(
    parameter int ADDR_WIDTH  = 5,
    parameter int MAC_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   size_x,
    input  logic [ADDR_WIDTH:0]   size_y,
    input  logic                  mac_ready,
    output logic [ADDR_WIDTH-1:0] addr_x,
    output logic [ADDR_WIDTH-1:0] addr_y,
    output logic                  mac_en,
    output logic                  acc_clr,
    output logic [ADDR_WIDTH:0]   addr_z,
    output logic                  z_wr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_CLEAR, S_SCAN, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t        state_q;
    logic [AW:0]   sx_q, sy_q, n_q, n_last_q;
    logic [AW-1:0] k_q, k_last_q;
    logic [3:0]    wait_q;

    logic [AW-1:0] addr_x_q, addr_y_q;
    logic [AW:0]   addr_z_q;
    logic          mac_en_q, acc_clr_q, z_wr_q, busy_q, done_q, err_q;

    logic [AW-1:0] sx_m1, k_first_d, k_last_d, k_cur;
    logic [DW-1:0] re_out;
    logic          j_in_range, advance, last_k, issue;

    // Modular AW-bit arithmetic is exact here because the true result always fits in AW bits.
    assign sx_m1 = sx_q[AW-1:0] - 1'b1;

    always_comb begin
        k_first_d = '0;
        k_last_d  = sx_m1;
`ifdef CONV_SEQ_BOUNDED_K_EN
        if (n_q >= sy_q) k_first_d = n_q[AW-1:0] + 1'b1 - sy_q[AW-1:0];
        if (n_q < sx_q)  k_last_d  = n_q[AW-1:0];
`endif
    end

    // CLEAR evaluates the first k; SCAN evaluates the k after the one currently presented.
    assign k_cur   = (state_q == S_CLEAR) ? k_first_d : k_q + 1'b1;
    assign advance = !mac_en_q || mac_ready;
    assign last_k  = (k_q == k_last_q);
    assign issue   = (state_q == S_CLEAR) || ((state_q == S_SCAN) && advance && !last_k);

    convolution_coprocessor_substractor #(
        .DATA_WIDTH(DW)
    ) u_sub (
        .re_A  ({1'b0, n_q}),
        .re_B  ({2'b00, k_cur}),
        .re_out(re_out)
    );

    assign j_in_range = !re_out[DW-1] && (re_out[AW:0] < sy_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sx_q      <= '0;
            sy_q      <= '0;
            n_q       <= '0;
            n_last_q  <= '0;
            k_q       <= '0;
            k_last_q  <= '0;
            wait_q    <= '0;
            addr_x_q  <= '0;
            addr_y_q  <= '0;
            addr_z_q  <= '0;
            mac_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            z_wr_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            z_wr_q    <= 1'b0;
            done_q    <= 1'b0;

            if (issue) begin
                k_q      <= k_cur;
                addr_x_q <= k_cur;
                addr_y_q <= re_out[AW-1:0];
                mac_en_q <= j_in_range;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (size_x == '0 || size_y == '0) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            err_q     <= 1'b0;
                            sx_q      <= size_x;
                            sy_q      <= size_y;
                            n_last_q  <= size_x + size_y - (AW+1)'(2);
                            n_q       <= '0;
                            acc_clr_q <= 1'b1;
                            state_q   <= S_CLEAR;
                        end
                    end
                end
                S_ERR: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_CLEAR: begin
                    k_last_q <= k_last_d;
                    state_q  <= S_SCAN;
                end
                S_SCAN: begin
                    if (advance && last_k) begin
                        mac_en_q <= 1'b0;
                        if (MAC_LATENCY == 0) begin
                            z_wr_q   <= 1'b1;
                            addr_z_q <= n_q;
                            state_q  <= S_WRITE;
                        end else begin
                            wait_q  <= 4'd1;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (wait_q == 4'(MAC_LATENCY)) begin
                        wait_q   <= '0;
                        z_wr_q   <= 1'b1;
                        addr_z_q <= n_q;
                        state_q  <= S_WRITE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (n_q == n_last_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        n_q       <= n_q + 1'b1;
                        acc_clr_q <= 1'b1;
                        state_q   <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_SEQ_BOUNDED_K_EN
    // With the bounded window every evaluated k must land on a valid y sample.
    always_ff @(posedge clk) begin
        if (!rst && issue) begin
            assert (j_in_range);
        end
    end
`endif

    assign addr_x  = addr_x_q;
    assign addr_y  = addr_y_q;
    assign mac_en  = mac_en_q;
    assign acc_clr = acc_clr_q;
    assign addr_z  = addr_z_q;
    assign z_wr    = z_wr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_convolution_coprocessor_index_sequencer.sv
// Scoreboard bench for the convolution index sequencer: stimulus pushes expected beats/writes/done, a monitor pops and compares.
module tb_convolution_coprocessor_index_sequencer;
    localparam int AW = 5;
    localparam int ML = 2;
`ifdef CONV_SEQ_BOUNDED_K_EN
    localparam bit BND = 1'b1;
`else
    localparam bit BND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, mac_ready;
    logic [AW:0]   size_x, size_y;
    logic [AW-1:0] addr_x, addr_y;
    logic          mac_en, acc_clr, z_wr, busy, done, err;
    logic [AW:0]   addr_z;

    convolution_coprocessor_index_sequencer #(
        .ADDR_WIDTH (AW),
        .MAC_LATENCY(ML)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .size_x   (size_x),
        .size_y   (size_y),
        .mac_ready(mac_ready),
        .addr_x   (addr_x),
        .addr_y   (addr_y),
        .mac_en   (mac_en),
        .acc_clr  (acc_clr),
        .addr_z   (addr_z),
        .z_wr     (z_wr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int ax; int ay; } beat_t;
    beat_t exp_beats[$];
    int    exp_wr_addr[$];
    int    exp_wr_ncyc[$];
    int    exp_done_cyc[$];
    int    exp_done_err[$];

    int   clr_cyc = 0, clr_since_wr = 0, clr_total = 0, done_cnt = 0;
    logic prev_stall = 1'b0;
    int   prev_ax = 0, prev_ay = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall   = 1'b0;
            clr_since_wr = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_mac_en", int'(mac_en), 1);
                chk("stall_hold_addr_x", int'(addr_x), prev_ax);
                chk("stall_hold_addr_y", int'(addr_y), prev_ay);
            end
            prev_stall = mac_en && !mac_ready;
            prev_ax    = int'(addr_x);
            prev_ay    = int'(addr_y);
            if (acc_clr) begin
                clr_cyc = cyc;
                clr_since_wr++;
                clr_total++;
            end
            if (mac_en && mac_ready) begin
                $display("beat x=%0d y=%0d cycle=%0d", addr_x, addr_y, cyc);
                if (exp_beats.size() == 0) fail("unexpected_beat");
                else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    chk("beat_addr_x", int'(addr_x), b.ax);
                    chk("beat_addr_y", int'(addr_y), b.ay);
                end
            end
            if (z_wr) begin
                $display("z_wr addr_z=%0d cycle=%0d", addr_z, cyc);
                if (exp_wr_addr.size() == 0) fail("unexpected_z_wr");
                else begin
                    chk("z_wr_addr", int'(addr_z), exp_wr_addr.pop_front());
                    chk("n_cycle_count", cyc - clr_cyc + 1, exp_wr_ncyc.pop_front());
                    chk("acc_clr_per_z_wr", clr_since_wr, 1);
                end
                clr_since_wr = 0;
            end
            if (done) begin
                $display("done err=%0d cycle=%0d", err, cyc);
                if (exp_done_cyc.size() == 0) fail("unexpected_done");
                else begin
                    chk("done_cycle", cyc, exp_done_cyc.pop_front());
                    chk("done_err", int'(err), exp_done_err.pop_front());
                end
                done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int sx, input int sy, output int c);
        size_x = (AW+1)'(sx);
        size_y = (AW+1)'(sy);
        start  = 1'b1;
        c      = cyc;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            tick();
        end
        if (done_cnt < target) fail(name);
    endtask

    task automatic push_beat(input int ax, input int ay);
        beat_t b;
        b.ax = ax;
        b.ay = ay;
        exp_beats.push_back(b);
    endtask

    // Hand-computed 3x2 sequence: (0,0) | (0,1),(1,0) | (1,1),(2,0) | (2,1)
    task automatic push_3x2(input int stall_extra, output int total);
        int ax[6] = '{0, 0, 1, 1, 2, 2};
        int ay[6] = '{0, 1, 0, 1, 0, 1};
        int nb[4] = '{1, 2, 2, 1};
        int nc;
        total = 0;
        for (int i = 0; i < 6; i++) push_beat(ax[i], ay[i]);
        for (int n = 0; n < 4; n++) begin
            nc = 2 + ML + (BND ? nb[n] : 3) + ((n == 1) ? stall_extra : 0);
            exp_wr_addr.push_back(n);
            exp_wr_ncyc.push_back(nc);
            total += nc;
        end
    endtask

    task automatic run_1x1(input string name);
        int c;
        push_beat(0, 0);
        exp_wr_addr.push_back(0);
        exp_wr_ncyc.push_back(2 + ML + 1);
        launch(1, 1, c);
        exp_done_cyc.push_back(c + 1 + 2 + ML + 1);
        exp_done_err.push_back(0);
        chk({name, "_err_cleared"}, int'(err), 0);
        chk({name, "_busy"}, int'(busy), 1);
        wait_done(50, {name, "_done_timeout"});
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_addr_x"}, int'(addr_x), 0);
        chk({name, "_addr_y"}, int'(addr_y), 0);
        chk({name, "_mac_en"}, int'(mac_en), 0);
        chk({name, "_acc_clr"}, int'(acc_clr), 0);
        chk({name, "_addr_z"}, int'(addr_z), 0);
        chk({name, "_z_wr"}, int'(z_wr), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_err"}, int'(err), 0);
    endtask

    task automatic chk_queues_empty(input string name);
        chk({name, "_beats_left"}, exp_beats.size(), 0);
        chk({name, "_z_wr_left"}, exp_wr_addr.size(), 0);
        chk({name, "_done_left"}, exp_done_cyc.size(), 0);
    endtask

    initial begin
        int c, total, saved_clr, clr_seen, nb, nc;
        rst = 1'b1; start = 1'b0; mac_ready = 1'b1;
        size_x = '0; size_y = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Run A: 3x2 plain, start while busy and start in DONE cycle both ignored
        push_3x2(0, total);
        launch(3, 2, c);
        exp_done_cyc.push_back(c + 1 + total);
        exp_done_err.push_back(0);
        repeat (4) tick();
        size_x = 1; size_y = 1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            tick();
        end
        if (!done) fail("runA_done_timeout");
        start = 1'b1;
        tick();
        start = 1'b0;
        saved_clr = clr_total;
        repeat (3) begin
            chk("after_done_busy", int'(busy), 0);
            tick();
        end
        chk("after_done_no_relaunch", clr_total, saved_clr);
        chk_queues_empty("runA");

        // Run B: 3 cycles of backpressure on beat (1,0)
        push_3x2(3, total);
        launch(3, 2, c);
        exp_done_cyc.push_back(c + 1 + total);
        exp_done_err.push_back(0);
        for (int i = 0; i < 100; i++) begin
            if (mac_en && addr_x == 1 && addr_y == 0) break;
            tick();
        end
        chk("stall_target_seen", int'(mac_en && addr_x == 1 && addr_y == 0), 1);
        mac_ready = 1'b0;
        repeat (3) tick();
        mac_ready = 1'b1;
        wait_done(200, "runB_done_timeout");
        chk_queues_empty("runB");

        // Zero size: err, done two cycles after start, no beats
        launch(3, 0, c);
        exp_done_cyc.push_back(c + 2);
        exp_done_err.push_back(1);
        chk("err_set", int'(err), 1);
        wait_done(20, "err_done_timeout");
        chk("err_held_idle", int'(err), 1);
        run_1x1("clear_err");
        chk_queues_empty("err_run");

        // Reset in the first SCAN cycle of n=1, then a 1x1 run
        push_beat(0, 0);
        exp_wr_addr.push_back(0);
        exp_wr_ncyc.push_back(2 + ML + (BND ? 1 : 3));
        launch(3, 2, c);
        clr_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (acc_clr) clr_seen++;
            if (clr_seen == 2) break;
            tick();
        end
        chk("midrun_clear_n1_seen", clr_seen, 2);
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("midrun_reset");
        rst = 1'b0;
        tick();
        chk_queues_empty("midrun");
        run_1x1("after_reset");
        chk_queues_empty("after_reset");

        // Maximum sizes: n reaches 2^(AW+1)-2 without wrapping addr_z
        total = 0;
        for (int n = 0; n <= 2 * (1 << AW) - 2; n++) begin
            nb = 0;
            for (int k = 0; k < (1 << AW); k++) begin
                if (n - k >= 0 && n - k < (1 << AW)) begin
                    push_beat(k, n - k);
                    nb++;
                end
            end
            nc = 2 + ML + (BND ? nb : (1 << AW));
            exp_wr_addr.push_back(n);
            exp_wr_ncyc.push_back(nc);
            total += nc;
        end
        launch(1 << AW, 1 << AW, c);
        exp_done_cyc.push_back(c + 1 + total);
        exp_done_err.push_back(0);
        wait_done(total + 50, "max_done_timeout");
        chk_queues_empty("max");

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
